// File: rtl/detect_faces_sdiv_26s_16ns_10s_seq.sv
// rtl/detect_faces_sdiv_26s_16ns_10s_seq.sv - sequential signed/unsigned restoring divider with saturated quotient
module detect_faces_sdiv_26s_16ns_10s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 26,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [din0_WIDTH-1:0] POS_LIM  = din0_WIDTH'((1 << (dout_WIDTH-1)) - 1);
    localparam logic [din0_WIDTH-1:0] NEG_LIM  = din0_WIDTH'(1 << (dout_WIDTH-1));
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                  state, state_nxt;
    logic                    sign;
    logic [din0_WIDTH-1:0]   mag;
    logic [din1_WIDTH-1:0]   dsr;
    logic [din1_WIDTH-1:0]   prem;
    logic [CW-1:0]           cnt;
    logic [din1_WIDTH:0]     shifted;
    logic                    qbit;
    logic [din0_WIDTH-1:0]   din0_abs;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (din1 == '0) ? FIN : CALC;
            CALC:    if (cnt == '0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // mag doubles as the quotient register: dividend bits shift out, quotient bits shift in
    always_comb begin
        din0_abs = din0[din0_WIDTH-1] ? (~din0 + din0_WIDTH'(1)) : din0;
        shifted  = {prem, mag[din0_WIDTH-1]};
        qbit     = (shifted >= {1'b0, dsr});
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sign <= 1'b0;
            mag  <= '0;
            dsr  <= '0;
            prem <= '0;
            cnt  <= '0;
            done <= 1'b0;
            dout <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            div0 <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign <= din0[din0_WIDTH-1];
                        mag  <= din0_abs;
                        dsr  <= din1;
                        prem <= '0;
                        cnt  <= CW'(din0_WIDTH - 1);
                    end
                end
                CALC: begin
                    prem <= qbit ? din1_WIDTH'(shifted - {1'b0, dsr}) : shifted[din1_WIDTH-1:0];
                    mag  <= {mag[din0_WIDTH-2:0], qbit};
                    cnt  <= cnt - CW'(1);
                end
                FIN: begin
                    done <= 1'b1;
                    if (dsr == '0) begin
                        dout <= sign ? DOUT_MIN : DOUT_MAX;
                        rem  <= mag[din1_WIDTH-1:0];
                        ovf  <= 1'b0;
                        div0 <= 1'b1;
                    end else begin
                        rem  <= prem;
                        div0 <= 1'b0;
                        if (!sign && mag > POS_LIM) begin
                            dout <= DOUT_MAX;
                            ovf  <= 1'b1;
                        end else if (sign && mag > NEG_LIM) begin
                            dout <= DOUT_MIN;
                            ovf  <= 1'b1;
                        end else begin
                            dout <= sign ? dout_WIDTH'(-mag) : mag[dout_WIDTH-1:0];
                            ovf  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
